// File: rtl/fgpio_capture.sv
// Fast-GPIO input capture: synchronises pins, detects enabled edges and
// queues timestamped events in a FIFO read through custom instructions.
module fgpio_capture #(
    parameter int FGPIO_NUM  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_neg_i,
    input  logic                 rst_ni,
    input  logic                 cap_req,
    input  logic [6:0]           cap_funct7,
    input  logic [31:0]          cap_rs1_val,
    input  logic [31:0]          cap_rs2_val,
    output logic                 cap_ack,
    output logic                 cap_error,
    output logic [31:0]          cap_rd_val,
    input  logic [FGPIO_NUM-1:0] gpio_in_val
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int N  = FGPIO_NUM;

    localparam logic [6:0] OP_CFG = 7'b0000000;
    localparam logic [6:0] OP_ST  = 7'b0000001;
    localparam logic [6:0] OP_POP = 7'b0000010;
    localparam logic [6:0] OP_CLR = 7'b0000011;

    logic [N-1:0]  sync1, sync2, prev;
    logic [N-1:0]  rise_en, fall_en;
    logic [N-1:0]  pend_r, pend_f;
    logic [N-1:0]  pend_r_nxt, pend_f_nxt;
    logic [N-1:0]  rise, fall;
    logic [N-1:0]  sel_mask, clr_r, clr_f;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          overflow, ovf_hit;
    logic [23:0]   ts;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [31:0]   head, entry;

    logic          is_cfg, is_st, is_pop, is_clr;
    logic          empty, full, pop_fire, enq;
    logic          sel_valid, sel_rise;
    logic [5:0]    sel_pin;
    logic [63:0]   rs1_ext, rs2_ext;
    logic [7:0]    count8;
    logic          unused;

    assign is_cfg = cap_req && (cap_funct7 == OP_CFG);
    assign is_st  = cap_req && (cap_funct7 == OP_ST);
    assign is_pop = cap_req && (cap_funct7 == OP_POP);
    assign is_clr = cap_req && (cap_funct7 == OP_CLR);

    assign rs1_ext = {32'b0, cap_rs1_val};
    assign rs2_ext = {32'b0, cap_rs2_val};
    assign unused  = ^{rs1_ext, rs2_ext};

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign count8   = 8'(count);
    assign head     = mem[rptr];
    assign pop_fire = is_pop && !empty;

    assign rise = sync2 & ~prev & rise_en;
    assign fall = ~sync2 & prev & fall_en;

    // Descending scan so the lowest pin wins, rise checked last to win over fall.
    always_comb begin
        sel_valid = 1'b0;
        sel_rise  = 1'b0;
        sel_pin   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_f[i]) begin
                sel_valid = 1'b1;
                sel_rise  = 1'b0;
                sel_pin   = 6'(i);
            end
            if (pend_r[i]) begin
                sel_valid = 1'b1;
                sel_rise  = 1'b1;
                sel_pin   = 6'(i);
            end
        end
    end

    assign enq      = sel_valid && (!full || pop_fire) && !is_clr;
    assign sel_mask = N'(1) << sel_pin;
    assign entry    = {1'b1, sel_rise, sel_pin, ts};

    always_comb begin
        clr_r      = '0;
        clr_f      = '0;
        if (enq) begin
            if (sel_rise) clr_r = sel_mask;
            else          clr_f = sel_mask;
        end
        pend_r_nxt = (pend_r & ~clr_r) | rise;
        pend_f_nxt = (pend_f & ~clr_f) | fall;
        ovf_hit    = |(rise & pend_r & ~clr_r) | |(fall & pend_f & ~clr_f);
    end

    always_ff @(posedge clk_neg_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= gpio_in_val;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk_neg_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_en  <= '0;
            fall_en  <= '0;
            pend_r   <= '0;
            pend_f   <= '0;
            overflow <= 1'b0;
            ts       <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else if (is_clr) begin
            pend_r   <= '0;
            pend_f   <= '0;
            overflow <= 1'b0;
            ts       <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            ts       <= ts + 24'd1;
            overflow <= overflow | ovf_hit;
            if (is_cfg) begin
                rise_en <= rs1_ext[N-1:0];
                fall_en <= rs2_ext[N-1:0];
                pend_r  <= pend_r_nxt & rs1_ext[N-1:0];
                pend_f  <= pend_f_nxt & rs2_ext[N-1:0];
            end else begin
                pend_r  <= pend_r_nxt;
                pend_f  <= pend_f_nxt;
            end
            if (enq)      wptr <= wptr + AW'(1);
            if (pop_fire) rptr <= rptr + AW'(1);
            unique case ({enq, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_neg_i) begin
        if (enq) mem[wptr] <= entry;
    end

    assign cap_ack = cap_req;

    always_comb begin
        cap_rd_val = '0;
        cap_error  = 1'b0;
        if (cap_req) begin
            case (cap_funct7)
                OP_CFG:  cap_rd_val = '0;
                OP_ST:   cap_rd_val = {overflow, full, empty, 21'b0, count8};
                OP_POP:  cap_rd_val = empty ? 32'h0 : head;
                OP_CLR:  cap_rd_val = '0;
                default: cap_error  = 1'b1;
            endcase
        end
    end

    logic unused_st;
    assign unused_st = is_st;

endmodule
